// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side framer: FSM states,
// discard reason codes and the default start-of-frame marker.
package uart_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_EMIT
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one synchronous write
// port and one combinational read port. Contents are not reset.
module frame_buf #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  // Write port: store one payload byte per accepted write.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-stream framer: hunts for SOF, captures a length-prefixed payload,
// verifies the XOR checksum and replays verified payloads downstream.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF            = SOF_DEFAULT,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 666
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    wr_q, wr_d;
  logic [7:0]    rd_q, rd_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          done_q, done_d;

  logic          accept;
  logic          buf_we;
  logic          emit_last;
  logic [7:0]    buf_rdata;

  frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign rx_data_ready = (state_q != S_EMIT);
  assign accept        = rx_data_valid && rx_data_ready;
  assign emit_last     = (rd_q == len_q - 8'd1);

  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = out_valid ? buf_rdata : '0;
  assign out_last   = out_valid && emit_last;
  assign frame_done = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

  // State, counters and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
      len_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: framing, checksum, emit sequencing and timeout.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    code_d  = code_q;
    done_d  = 1'b0;
    buf_we  = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        if (accept && rx_data == SOF) begin
          state_d = S_LEN;
          wr_d    = '0;
          rd_d    = '0;
          acc_d   = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = rx_data;
          acc_d = rx_data;
          if (rx_data > MAX_LEN_B) begin
            state_d = S_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else if (rx_data == 8'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          wr_d   = wr_q + 8'd1;
          acc_d  = acc_q ^ rx_data;
          if (wr_q == len_q - 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data != acc_q) begin
            state_d = S_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end else if (len_q != 8'd0) begin
            state_d = S_EMIT;
            rd_d    = '0;
          end else begin
            state_d = S_HUNT;
            done_d  = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          rd_d = rd_q + 8'd1;
          if (emit_last) begin
            state_d = S_HUNT;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // An accepted byte on the expiry cycle takes priority over the timeout.
    if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) &&
        !accept && cnt_q == TO_LAST) begin
      state_d = S_HUNT;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end

    if (accept || state_d != state_q ||
        !(state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomised self-checking bench for uart_frame_parser. Expected results
// come from how each frame is built, not from the parser's internals.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 666;
  localparam logic [7:0]  SOF     = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;
  logic       err;
  logic [1:0] err_code;

  uart_frame_parser #(
    .SOF            (SOF),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .err           (err),
    .err_code      (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus and expectation for the frame being run.
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_code;
  int unsigned exp_done;

  // Observed downstream traffic.
  logic [7:0] got_q[$];
  logic       got_last[$];
  int unsigned err_cnt  = 0;
  int unsigned done_cnt = 0;
  int unsigned rdy_mode = 0;

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    int unsigned ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sample mid-cycle, log handshakes and pulses, check stall rules.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          chk("rdy_in_emit", {31'd0, rx_data_ready}, 32'd0);
          if (prev_stall) begin
            chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
          end
        end else if (prev_stall) begin
          chk("valid_dropped", 32'd0, 32'd1);
        end
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          got_last.push_back(out_last);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (err) err_cnt++;
        if (frame_done) done_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Present one byte and hold it until accepted; returns 1 ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned guard;
    guard = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_data_ready) break;
      guard++;
      if (guard > 5000) begin
        chk("accept_wait", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] noise_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SOF);
    return b;
  endfunction

  // Build a frame of the given kind into tx_q with its expected outcome.
  task automatic build(input int unsigned kind);
    logic [7:0] len, cs, b;
    int unsigned nn;
    tx_q.delete();
    exp_q.delete();
    exp_code = 2'd0;
    exp_done = 0;
    nn = $urandom_range(0, 2);
    repeat (nn) tx_q.push_back(noise_byte());
    tx_q.push_back(SOF);
    case (kind)
      0, 1: begin
        len = 8'($urandom_range(1, MAX_LEN));
        tx_q.push_back(len);
        cs = len;
        for (int i = 0; i < int'(len); i++) begin
          b = 8'($urandom);
          tx_q.push_back(b);
          exp_q.push_back(b);
          cs = cs ^ b;
        end
        if (kind == 1) begin
          cs = cs ^ 8'($urandom_range(1, 255));
          exp_q.delete();
          exp_code = 2'd1;
        end else begin
          exp_done = 1;
        end
        tx_q.push_back(cs);
      end
      2: begin
        tx_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        nn = $urandom_range(0, 3);
        repeat (nn) tx_q.push_back(noise_byte());
        exp_code = 2'd2;
      end
      default: begin
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        exp_done = 1;
      end
    endcase
  endtask

  // Send tx_q with short random gaps, wait for the outcome, compare.
  task automatic run_frame(input string name);
    int unsigned eb, db, guard;
    eb = err_cnt;
    db = done_cnt;
    got_q.delete();
    got_last.delete();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      idle($urandom_range(0, 3));
    end
    guard = 0;
    while (err_cnt + done_cnt == eb + db && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk({name, "_outcome_wait"}, 32'd0, 32'd1);
    idle(3);
    chk({name, "_n_out"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      chk({name, "_last"}, {31'd0, got_last[i]}, (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
    end
    chk({name, "_err_n"}, err_cnt - eb, (exp_code != 2'd0) ? 32'd1 : 32'd0);
    if (exp_code != 2'd0) chk({name, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
    chk({name, "_done_n"}, done_cnt - db, exp_done);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_rdy"},   {31'd0, rx_data_ready}, 32'd1);
    chk({name, "_valid"}, {31'd0, out_valid},     32'd0);
    chk({name, "_last"},  {31'd0, out_last},      32'd0);
    chk({name, "_data"},  {24'd0, out_data},      32'd0);
    chk({name, "_done"},  {31'd0, frame_done},    32'd0);
    chk({name, "_err"},   {31'd0, err},           32'd0);
  endtask

  initial begin
    int unsigned eb, db, cyc;
    rst_n         = 1'b0;
    rx_data       = '0;
    rx_data_valid = 1'b0;
    idle(3);
    check_idle_outputs("reset");
    chk("reset_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame from the worked example.
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_q = '{8'h11, 8'h22, 8'h33};
    exp_code = 2'd0; exp_done = 1;
    run_frame("good");

    // Bad checksum, then a clean frame.
    tx_q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
    exp_q.delete(); exp_code = 2'd1; exp_done = 0;
    run_frame("badcs");
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_q = '{8'h7E}; exp_code = 2'd0; exp_done = 1;
    run_frame("noise_good");

    // Oversize header, trailing noise, then empty frame.
    tx_q = '{8'hA5, 8'h11, 8'h01, 8'h02};
    exp_q.delete(); exp_code = 2'd2; exp_done = 0;
    run_frame("oversize");
    tx_q = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    exp_q = '{16{8'h00}}; exp_code = 2'd0; exp_done = 1;
    run_frame("maxlen");
    tx_q = '{8'hA5, 8'h00, 8'h00};
    exp_q.delete(); exp_code = 2'd0; exp_done = 1;
    run_frame("empty");

    // Timeout: silence after the first payload byte.
    eb = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (err) break;
    end
    chk("timeout_cycles", cyc, TMO);
    chk("timeout_code", {30'd0, err_code}, 32'd3);
    idle(2);
    chk("timeout_err_n", err_cnt - eb, 32'd1);
    tx_q = '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h03};
    exp_q = '{8'h40, 8'h41}; exp_code = 2'd0; exp_done = 1;
    run_frame("after_tmo");

    // Backpressure pattern on a 4-byte frame.
    rdy_mode = 1;
    tx_q = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF};
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; exp_code = 2'd0; exp_done = 1;
    run_frame("bp");

    // Reset in the middle of a payload.
    rdy_mode = 0;
    eb = err_cnt;
    db = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("midrst_err_n", err_cnt - eb, 32'd0);
    chk("midrst_done_n", done_cnt - db, 32'd0);
    tx_q = '{8'hA5, 8'h01, 8'h55, 8'h54};
    exp_q = '{8'h55}; exp_code = 2'd0; exp_done = 1;
    run_frame("after_rst");

    // Random mix of frame kinds with random downstream readiness.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      build($urandom_range(0, 3));
      run_frame("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream framer sitting directly downstream of the UART receiver in the TX/RX path. It consumes received bytes over a valid/ready handshake, hunts for a start-of-frame byte, and captures a length-prefixed payload into an internal buffer. It checks an XOR checksum and releases only verified payloads to the next stage as a valid/ready byte stream with a last marker. Malformed, oversize and stalled frames are discarded and reported as one-cycle error pulses.

## Interface
- SOF, 8'hA5, start-of-frame byte
- MAX_LEN, 16, maximum payload bytes, 1..255
- TIMEOUT_CYCLES, 666, idle clocks allowed between accepted bytes inside a frame (about 20 bit-times at 50 MHz / 1.5 Mbaud)

- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from the UART receiver
- rx_data_valid  in  1  rx_data is valid
- rx_data_ready  out  1  parser accepts a byte this cycle
- out_data  out  8  payload byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks the final payload byte of the frame
- frame_done  out  1  one-cycle pulse after the last byte handshake
- err  out  1  one-cycle pulse when a frame is discarded
- err_code  out  2  reason for the discard: 1 = checksum, 2 = length, 3 = timeout; held until the next err

## Operation
- Wire format: SOF, LEN, LEN payload bytes, CSUM, where CSUM = LEN ^ payload[0] ^ … ^ payload[LEN-1].
- A byte is accepted on any cycle where rx_data_valid and rx_data_ready are both high.
- States and transitions:
  - S_HUNT: an accepted byte equal to SOF goes to S_LEN; any other byte is dropped silently.
  - S_LEN: an accepted byte is stored as len and seeds the running XOR acc.
    - LEN > MAX_LEN: err with code 2, go to S_HUNT.
    - LEN = 0: go to S_CSUM.
    - Otherwise: go to S_PAYLOAD.
  - S_PAYLOAD: each accepted byte is written to buf[wr_idx], wr_idx increments, and acc ^= byte. The byte with wr_idx = len-1 moves to S_CSUM.
  - S_CSUM: the accepted byte is compared with acc.
    - Match and len > 0: go to S_EMIT.
    - Match and len = 0: pulse frame_done, go to S_HUNT.
    - Mismatch: err with code 1, go to S_HUNT.
  - S_EMIT: out_valid is high and out_data = buf[rd_idx]. Each out handshake increments rd_idx. out_last = (rd_idx == len-1). The last handshake pulses frame_done and goes to S_HUNT.
- rx_data_ready is 0 only in S_EMIT. It is 1 in every other state, including the cycle that enters S_EMIT.
- Upstream backpressure during S_EMIT stalls the receiver in its hold state. Bytes arriving on the line during that time may be lost upstream; this is accepted behaviour.
- Timeout counter:
  - Runs only in S_LEN, S_PAYLOAD and S_CSUM.
  - Clears on every accepted byte and on every state change.
  - Reaching TIMEOUT_CYCLES-1 raises err with code 3 and returns to S_HUNT.
  - If a byte is accepted on the same cycle the timeout would fire, the byte wins and no timeout occurs.
- wr_idx, rd_idx and acc clear on entry to S_LEN.

## Timing
- Reset values:
  - state = S_HUNT
  - rx_data_ready = 1
  - out_valid = 0, out_last = 0, out_data = 0
  - frame_done = 0, err = 0, err_code = 0
  - buffer contents are don't-care
- Latency: out_valid rises on the clock after the CSUM byte is accepted.
- out_data and out_last are stable while out_valid is high and out_ready is low. out_valid never drops without a handshake.
- The downstream can sustain one byte per cycle when out_ready is held high.
- Checksum is evaluated on the acceptance cycle of the CSUM byte. err and frame_done are registered one-cycle pulses that appear on the following cycle.
- Deasserting rst_n mid-frame or mid-emit aborts immediately: the partial frame is dropped and no err is reported.

## Structure
- A shared package `uart_pkg` holds:
  - the state enum (S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_EMIT)
  - the err_code constants ERR_NONE / ERR_CSUM / ERR_LEN / ERR_TIMEOUT
  - the default SOF value
- The payload buffer is a separate sub-module, `frame_buf`: a MAX_LEN x 8 register array with one synchronous write port and one combinational read port.
- FSM, counters and checksum logic live in the top module.

## Test plan
- Good frame: A5 03 11 22 33 CSUM=03^11^22^33=03 -> out bytes 11, 22, 33; out_last on 33; one frame_done pulse; no err.
- Bad checksum: A5 02 AA BB 00 (correct CSUM is 13) -> no out_valid; err pulse with err_code=1; next good frame is parsed normally.
- Oversize and empty frames:
  - A5 11 with MAX_LEN=16 -> err_code=2; the following bytes are hunted as noise until the next A5.
  - A5 00 00 -> frame_done pulse with no out_valid.
- Timeout: A5 04 01, then silence for TIMEOUT_CYCLES -> err_code=3 exactly TIMEOUT_CYCLES clocks after byte 01 is accepted; state is back in S_HUNT.
- Backpressure: good 4-byte frame with out_ready toggling 1,0,0,1,… -> data is held stable during stalls, every byte is delivered exactly once in order, and rx_data_ready stays 0 throughout S_EMIT.
- Noise and reset:
  - Leading bytes 00 FF 5A before A5 are dropped without err.
  - Asserting rst_n low during S_PAYLOAD returns all outputs to their reset values, with no err or frame_done pulse.
